ex_mem_flag_stage: RTL and testbench

- EX→MEM pipeline boundary directly downstream of the ALU (ADD/SUB/XOR/RED/SLL/SRA/ROR/PADDSB result mux).
- Registers the ALU result and control for the MEM stage.
- Owns the architectural Z/V/N flag register, updated per opcode class.
- Latches HLT and counts retired-into-MEM instructions.

---
 rtl/ex_mem_flag_stage.sv | 152 +++++++++++++++
 tb/tb_ex_mem_flag_stage.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_flag_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_flag_stage
// Brief    : EX->MEM pipeline register with architectural Z/V/N flags,
//            sticky halt latch and advance counter.
// Revision : 1.0 - initial release
// ============================================================================
module ex_mem_flag_stage #(
    parameter int DATA_W = 16,
    parameter int RA_W   = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic [3:0]        ex_opcode,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              ex_ovf,
    input  logic [RA_W-1:0]   ex_rd,
    input  logic              ex_reg_wr,
    input  logic              ex_mem_rd,
    input  logic              ex_mem_wr,
    input  logic [DATA_W-1:0] ex_store_data,
    output logic              mem_valid,
    output logic [3:0]        mem_opcode,
    output logic [DATA_W-1:0] mem_result,
    output logic [RA_W-1:0]   mem_rd,
    output logic              mem_reg_wr,
    output logic              mem_mem_rd,
    output logic              mem_mem_wr,
    output logic [DATA_W-1:0] mem_store_data,
    output logic              flag_z,
    output logic              flag_v,
    output logic              flag_n,
    output logic              halted,
    output logic [CNT_W-1:0]  adv_cnt
);

    localparam logic [3:0]       c_OP_ADD = 4'b0000;
    localparam logic [3:0]       c_OP_SUB = 4'b0001;
    localparam logic [3:0]       c_OP_XOR = 4'b0010;
    localparam logic [3:0]       c_OP_SLL = 4'b0100;
    localparam logic [3:0]       c_OP_SRA = 4'b0101;
    localparam logic [3:0]       c_OP_ROR = 4'b0110;
    localparam logic [3:0]       c_OP_HLT = 4'b1111;
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              r_valid;
    logic [3:0]        r_opcode;
    logic [DATA_W-1:0] r_result;
    logic [RA_W-1:0]   r_rd;
    logic              r_reg_wr;
    logic              r_mem_rd;
    logic              r_mem_wr;
    logic [DATA_W-1:0] r_store_data;
    logic              r_z;
    logic              r_v;
    logic              r_n;
    logic              r_halted;
    logic [CNT_W-1:0]  r_cnt;

    logic w_eff_v;
    logic w_upd_z;
    logic w_upd_vn;
    logic w_is_hlt;

    // Once halted, everything arriving from EX is treated as a bubble.
    assign w_eff_v  = ex_valid & ~r_halted;
    assign w_is_hlt = (ex_opcode == c_OP_HLT);

    always_comb begin
        w_upd_z  = 1'b0;
        w_upd_vn = 1'b0;
        case (ex_opcode)
            c_OP_ADD, c_OP_SUB: begin
                w_upd_z  = 1'b1;
                w_upd_vn = 1'b1;
            end
            c_OP_XOR, c_OP_SLL, c_OP_SRA, c_OP_ROR: begin
                w_upd_z  = 1'b1;
            end
            default: begin
                w_upd_z  = 1'b0;
                w_upd_vn = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_opcode     <= '0;
            r_result     <= '0;
            r_rd         <= '0;
            r_reg_wr     <= 1'b0;
            r_mem_rd     <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_store_data <= '0;
            r_z          <= 1'b0;
            r_v          <= 1'b0;
            r_n          <= 1'b0;
            r_halted     <= 1'b0;
            r_cnt        <= '0;
        end else if (flush) begin
            // Bubble insertion: data fields hold, only valid/controls clear.
            r_valid  <= 1'b0;
            r_reg_wr <= 1'b0;
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
        end else if (!stall) begin
            r_valid      <= w_eff_v;
            r_opcode     <= ex_opcode;
            r_result     <= ex_result;
            r_rd         <= ex_rd;
            r_reg_wr     <= ex_reg_wr & w_eff_v;
            r_mem_rd     <= ex_mem_rd & w_eff_v;
            r_mem_wr     <= ex_mem_wr & w_eff_v;
            r_store_data <= ex_store_data;
            if (w_eff_v) begin
                if (w_upd_z) begin
                    r_z <= (ex_result == '0);
                end
                if (w_upd_vn) begin
                    r_v <= ex_ovf;
                    r_n <= ex_result[DATA_W-1];
                end
                if (w_is_hlt) begin
                    r_halted <= 1'b1;
                end
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
    end

    assign mem_valid      = r_valid;
    assign mem_opcode     = r_opcode;
    assign mem_result     = r_result;
    assign mem_rd         = r_rd;
    assign mem_reg_wr     = r_reg_wr;
    assign mem_mem_rd     = r_mem_rd;
    assign mem_mem_wr     = r_mem_wr;
    assign mem_store_data = r_store_data;
    assign flag_z         = r_z;
    assign flag_v         = r_v;
    assign flag_n         = r_n;
    assign halted         = r_halted;
    assign adv_cnt        = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_flag_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mem_flag_stage
// Brief    : Directed self-checking bench for ex_mem_flag_stage.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ex_mem_flag_stage;

    localparam int DATA_W = 16;
    localparam int RA_W   = 4;
    localparam int CNT_W  = 16;

    logic              clk;
    logic              rst_n;
    logic              stall;
    logic              flush;
    logic              ex_valid;
    logic [3:0]        ex_opcode;
    logic [DATA_W-1:0] ex_result;
    logic              ex_ovf;
    logic [RA_W-1:0]   ex_rd;
    logic              ex_reg_wr;
    logic              ex_mem_rd;
    logic              ex_mem_wr;
    logic [DATA_W-1:0] ex_store_data;
    logic              mem_valid;
    logic [3:0]        mem_opcode;
    logic [DATA_W-1:0] mem_result;
    logic [RA_W-1:0]   mem_rd;
    logic              mem_reg_wr;
    logic              mem_mem_rd;
    logic              mem_mem_wr;
    logic [DATA_W-1:0] mem_store_data;
    logic              flag_z;
    logic              flag_v;
    logic              flag_n;
    logic              halted;
    logic [CNT_W-1:0]  adv_cnt;

    int vectors;
    int miscompares;

    ex_mem_flag_stage #(
        .DATA_W(DATA_W),
        .RA_W  (RA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .flush         (flush),
        .ex_valid      (ex_valid),
        .ex_opcode     (ex_opcode),
        .ex_result     (ex_result),
        .ex_ovf        (ex_ovf),
        .ex_rd         (ex_rd),
        .ex_reg_wr     (ex_reg_wr),
        .ex_mem_rd     (ex_mem_rd),
        .ex_mem_wr     (ex_mem_wr),
        .ex_store_data (ex_store_data),
        .mem_valid     (mem_valid),
        .mem_opcode    (mem_opcode),
        .mem_result    (mem_result),
        .mem_rd        (mem_rd),
        .mem_reg_wr    (mem_reg_wr),
        .mem_mem_rd    (mem_mem_rd),
        .mem_mem_wr    (mem_mem_wr),
        .mem_store_data(mem_store_data),
        .flag_z        (flag_z),
        .flag_v        (flag_v),
        .flag_n        (flag_n),
        .halted        (halted),
        .adv_cnt       (adv_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stimulus helper only; all checking lives in the test tasks.
    task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] res,
                         input logic ovf, input logic [3:0] rd, input logic rw,
                         input logic mr, input logic mw, input logic [15:0] sd);
        ex_valid      = v;
        ex_opcode     = op;
        ex_result     = res;
        ex_ovf        = ovf;
        ex_rd         = rd;
        ex_reg_wr     = rw;
        ex_mem_rd     = mr;
        ex_mem_wr     = mw;
        ex_store_data = sd;
    endtask

    task automatic test_reset;
        logic [79:0] all_out;
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        all_out = {mem_valid, mem_opcode, mem_result, mem_rd, mem_reg_wr, mem_mem_rd,
                   mem_mem_wr, mem_store_data, flag_z, flag_v, flag_n, halted, adv_cnt};
        vectors++;
        if (all_out !== 80'h0) begin
            miscompares++;
            $display("FAIL reset_state: got %h expected 0", all_out);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid;
        logic [79:0] all_out;
        drive(1'b1, 4'h0, 16'h0000, 1'b0, 4'h2, 1'b1, 1'b0, 1'b0, 16'h1111);
        @(posedge clk);
        #1;
        vectors++;
        if ({mem_valid, flag_z, adv_cnt} !== {1'b1, 1'b1, 16'd1}) begin
            miscompares++;
            $display("FAIL add_zero_load: valid/z/cnt got %b/%b/%0d expected 1/1/1",
                     mem_valid, flag_z, adv_cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        all_out = {mem_valid, mem_opcode, mem_result, mem_rd, mem_reg_wr, mem_mem_rd,
                   mem_mem_wr, mem_store_data, flag_z, flag_v, flag_n, halted, adv_cnt};
        vectors++;
        if (all_out !== 80'h0) begin
            miscompares++;
            $display("FAIL async_reset: got %h expected 0 before next edge", all_out);
        end
        #1 rst_n = 1'b1;
        drive(1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic test_add_xor;
        drive(1'b1, 4'b0000, 16'h8000, 1'b1, 4'h3, 1'b1, 1'b0, 1'b0, 16'h0);
        @(posedge clk);
        #1;
        vectors++;
        if ({flag_z, flag_v, flag_n, mem_result, adv_cnt, mem_valid, mem_rd}
            !== {1'b0, 1'b1, 1'b1, 16'h8000, 16'd1, 1'b1, 4'h3}) begin
            miscompares++;
            $display("FAIL add_flags: zvn=%b%b%b res=%h cnt=%0d v=%b rd=%h expected zvn=011 res=8000 cnt=1 v=1 rd=3",
                     flag_z, flag_v, flag_n, mem_result, adv_cnt, mem_valid, mem_rd);
        end
        drive(1'b1, 4'b0010, 16'h0000, 1'b0, 4'h4, 1'b1, 1'b0, 1'b0, 16'h0);
        @(posedge clk);
        #1;
        vectors++;
        if ({flag_z, flag_v, flag_n, adv_cnt, mem_opcode} !== {1'b1, 1'b1, 1'b1, 16'd2, 4'b0010}) begin
            miscompares++;
            $display("FAIL xor_zonly: zvn=%b%b%b cnt=%0d op=%h expected zvn=111 cnt=2 op=2",
                     flag_z, flag_v, flag_n, adv_cnt, mem_opcode);
        end
    endtask

    task automatic test_red;
        drive(1'b1, 4'b0011, 16'hFF00, 1'b0, 4'h5, 1'b1, 1'b0, 1'b0, 16'h0);
        @(posedge clk);
        #1;
        vectors++;
        if ({flag_z, flag_v, flag_n, mem_result, mem_reg_wr, mem_rd, adv_cnt}
            !== {1'b1, 1'b1, 1'b1, 16'hFF00, 1'b1, 4'h5, 16'd3}) begin
            miscompares++;
            $display("FAIL red_noflags: zvn=%b%b%b res=%h rw=%b rd=%h cnt=%0d expected zvn=111 res=ff00 rw=1 rd=5 cnt=3",
                     flag_z, flag_v, flag_n, mem_result, mem_reg_wr, mem_rd, adv_cnt);
        end
    endtask

    task automatic test_store;
        drive(1'b1, 4'b1001, 16'h0040, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 16'hBEEF);
        @(posedge clk);
        #1;
        vectors++;
        if ({mem_mem_wr, mem_mem_rd, mem_reg_wr, mem_store_data, mem_result, flag_z, flag_v, flag_n, adv_cnt}
            !== {1'b1, 1'b0, 1'b0, 16'hBEEF, 16'h0040, 1'b1, 1'b1, 1'b1, 16'd4}) begin
            miscompares++;
            $display("FAIL store: mw=%b mr=%b rw=%b sd=%h res=%h zvn=%b%b%b cnt=%0d expected 1 0 0 beef 0040 111 4",
                     mem_mem_wr, mem_mem_rd, mem_reg_wr, mem_store_data, mem_result,
                     flag_z, flag_v, flag_n, adv_cnt);
        end
    endtask

    task automatic test_stall;
        drive(1'b1, 4'b0001, 16'h1234, 1'b0, 4'h7, 1'b1, 1'b1, 1'b0, 16'h0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if ({mem_result, mem_opcode, mem_mem_wr, flag_z, flag_v, flag_n, adv_cnt}
                !== {16'h0040, 4'b1001, 1'b1, 1'b1, 1'b1, 1'b1, 16'd4}) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: res=%h op=%h mw=%b zvn=%b%b%b cnt=%0d expected 0040 9 1 111 4",
                         i, mem_result, mem_opcode, mem_mem_wr, flag_z, flag_v, flag_n, adv_cnt);
            end
        end
        stall = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if ({mem_result, mem_opcode, mem_rd, mem_mem_rd, mem_mem_wr, flag_z, flag_v, flag_n, adv_cnt}
            !== {16'h1234, 4'b0001, 4'h7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5}) begin
            miscompares++;
            $display("FAIL stall_release: res=%h op=%h rd=%h mr=%b mw=%b zvn=%b%b%b cnt=%0d expected 1234 1 7 1 0 000 5",
                     mem_result, mem_opcode, mem_rd, mem_mem_rd, mem_mem_wr, flag_z, flag_v, flag_n, adv_cnt);
        end
    endtask

    task automatic test_flush_stall;
        drive(1'b1, 4'b0001, 16'h0000, 1'b0, 4'h8, 1'b1, 1'b1, 1'b1, 16'h0);
        flush = 1'b1;
        stall = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        stall = 1'b0;
        vectors++;
        if ({mem_valid, mem_reg_wr, mem_mem_rd, mem_mem_wr, flag_z, adv_cnt}
            !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5}) begin
            miscompares++;
            $display("FAIL flush_over_stall: v=%b rw=%b mr=%b mw=%b z=%b cnt=%0d expected 0 0 0 0 0 5",
                     mem_valid, mem_reg_wr, mem_mem_rd, mem_mem_wr, flag_z, adv_cnt);
        end
    endtask

    task automatic test_bubble;
        drive(1'b0, 4'b0000, 16'h0000, 1'b1, 4'h9, 1'b1, 1'b1, 1'b1, 16'h0);
        @(posedge clk);
        #1;
        vectors++;
        if ({mem_valid, mem_reg_wr, mem_mem_rd, mem_mem_wr, flag_z, flag_v, adv_cnt}
            !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5}) begin
            miscompares++;
            $display("FAIL bubble: v=%b rw=%b mr=%b mw=%b z=%b v=%b cnt=%0d expected 0 0 0 0 0 0 5",
                     mem_valid, mem_reg_wr, mem_mem_rd, mem_mem_wr, flag_z, flag_v, adv_cnt);
        end
    endtask

    task automatic test_halt;
        drive(1'b1, 4'b1111, 16'h0000, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        @(posedge clk);
        #1;
        vectors++;
        if ({halted, mem_valid, mem_opcode, adv_cnt, flag_z} !== {1'b1, 1'b1, 4'hF, 16'd6, 1'b0}) begin
            miscompares++;
            $display("FAIL hlt_enter: halted=%b v=%b op=%h cnt=%0d z=%b expected 1 1 f 6 0",
                     halted, mem_valid, mem_opcode, adv_cnt, flag_z);
        end
        drive(1'b1, 4'b0000, 16'h0000, 1'b1, 4'hA, 1'b1, 1'b0, 1'b0, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({halted, mem_valid, mem_reg_wr, flag_z, flag_v, adv_cnt} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd6}) begin
            miscompares++;
            $display("FAIL post_halt: halted=%b v=%b rw=%b z=%b v=%b cnt=%0d expected 1 0 0 0 0 6",
                     halted, mem_valid, mem_reg_wr, flag_z, flag_v, adv_cnt);
        end
    endtask

    task automatic test_wrap;
        rst_n = 1'b0;
        drive(1'b1, 4'b1000, 16'h0001, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0, 16'h0);
        #2 rst_n = 1'b1;
        vectors++;
        if ({halted, adv_cnt} !== {1'b0, 16'd0}) begin
            miscompares++;
            $display("FAIL halt_cleared: halted=%b cnt=%0d expected 0 0", halted, adv_cnt);
        end
        repeat (65535) @(posedge clk);
        #1;
        vectors++;
        if (adv_cnt !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL cnt_allones: got %h expected ffff", adv_cnt);
        end
        @(posedge clk);
        #1;
        vectors++;
        if ({adv_cnt, mem_valid} !== {16'h0000, 1'b1}) begin
            miscompares++;
            $display("FAIL cnt_wrap: cnt=%h v=%b expected 0000 1", adv_cnt, mem_valid);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_reset_mid();
        test_add_xor();
        test_red();
        test_store();
        test_stall();
        test_flush_stall();
        test_bubble();
        test_halt();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
